// File: rtl/sad_min_tracker_pkg.sv
// Shared definitions for the SAD minimum tracker and the difference stage feeding it.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package sad_min_tracker_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ACCUM   = ST_ACCUM,
    COMPARE = ST_COMPARE,
    DONE    = ST_DONE
  } state_t;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // SAD width: a full window of maximum differences cannot overflow
  function automatic int sad_width(input int diff_w, input int pix_per_cand);
    return diff_w + clog2(pix_per_cand);
  endfunction

  // Candidate index width, never narrower than one bit
  function automatic int idx_width(input int num_cand);
    return (clog2(num_cand) < 1) ? 1 : clog2(num_cand);
  endfunction

endpackage

// File: rtl/sad_min_compare.sv
// Registered best-SAD / best-index holder with init load and strict-less-than update.
// Latency: best_sad/best_idx reflect an enabled compare one cycle after en.
// Backpressure: none; en is a single-cycle qualifier driven by the owning FSM.
module sad_min_compare
  import sad_min_tracker_pkg::*;
#(
  parameter int SAD_W = 11,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             en,
  input  logic [SAD_W-1:0] sad,
  input  logic [IDX_W-1:0] idx,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx
);

  // Hold the running minimum; ties keep the earlier (already stored) index
  always_ff @(posedge clk) begin
    if (rst) begin
      best_sad <= '0;
      best_idx <= '0;
    end else if (init) begin
      best_sad <= '1;
      best_idx <= '0;
    end else if (en && (sad < best_sad)) begin
      best_sad <= sad;
      best_idx <= idx;
    end
  end

endmodule

// File: rtl/sad_min_tracker.sv
// Accumulates per-pixel absolute differences into per-candidate SADs and tracks the minimum.
// Latency: cand_valid one cycle after a candidate's last pixel, done/best one cycle later.
// Backpressure: in_ready is high only while accumulating; drops for the compare cycle and when idle.
module sad_min_tracker
  import sad_min_tracker_pkg::*;
#(
  parameter  int DIFF_W       = 5,
  parameter  int PIX_PER_CAND = 64,
  parameter  int NUM_CAND     = 16,
  localparam int SAD_W        = sad_width(DIFF_W, PIX_PER_CAND),
  localparam int IDX_W        = idx_width(NUM_CAND)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DIFF_W-1:0] diff_in,
  output logic              in_ready,
  output logic              busy,
  output logic              cand_valid,
  output logic [SAD_W-1:0]  cand_sad,
  output logic [IDX_W-1:0]  cand_idx,
  output logic              done,
  output logic [SAD_W-1:0]  best_sad,
  output logic [IDX_W-1:0]  best_idx
);

  localparam int PIX_W = clog2(PIX_PER_CAND);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_PER_CAND - 1);
  localparam logic [IDX_W-1:0] CAND_LAST = IDX_W'(NUM_CAND - 1);

  state_t            state;
  logic [SAD_W-1:0]  acc;
  logic [PIX_W-1:0]  pix_cnt;
  logic [IDX_W-1:0]  cand_cnt;
  logic              xfer;
  logic [SAD_W-1:0]  acc_next;
  logic              best_init;
  logic              best_en;

  assign xfer     = in_valid && in_ready;
  assign acc_next = acc + SAD_W'(diff_in);

  // Strobes and handshakes are pure decodes of the state register
  assign in_ready   = (state == ACCUM);
  assign busy       = (state != IDLE);
  assign cand_valid = (state == COMPARE);
  assign done       = (state == DONE);

  assign best_init = (state == IDLE) && start;
  assign best_en   = (state == COMPARE);

  // Search FSM with accumulator, pixel/candidate counters and held candidate result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      pix_cnt  <= '0;
      cand_cnt <= '0;
      cand_sad <= '0;
      cand_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            pix_cnt  <= '0;
            cand_cnt <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc <= acc_next;
            if (pix_cnt == PIX_LAST) begin
              pix_cnt  <= '0;
              cand_sad <= acc_next;
              cand_idx <= cand_cnt;
              state    <= COMPARE;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        COMPARE: begin
          acc <= '0;
          if (cand_cnt == CAND_LAST) begin
            state <= DONE;
          end else begin
            cand_cnt <= cand_cnt + 1'b1;
            state    <= ACCUM;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sad_min_compare #(
    .SAD_W (SAD_W),
    .IDX_W (IDX_W)
  ) u_compare (
    .clk      (clk),
    .rst      (rst),
    .init     (best_init),
    .en       (best_en),
    .sad      (acc),
    .idx      (cand_cnt),
    .best_sad (best_sad),
    .best_idx (best_idx)
  );

endmodule
